// File: rtl/out_decimal_sink_if.sv
// rtl/out_decimal_sink_if.sv - CPU output port and ASCII character stream bundle
//
// Signals:
//   out_strobe  CPU doOut strobe (capture byte on this posedge)
//   out_data    CPU dbus value accompanying out_strobe
//   char_valid  char_data holds a character
//   char_data   ASCII character
//   char_ready  downstream accepts the character on this edge
// Modports:
//   master  the decimal sink (sources the character stream)
//   slave   the environment (CPU side and console/UART side)
interface out_decimal_sink_if;
    logic       out_strobe;
    logic [7:0] out_data;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;

    modport master (
        input  out_strobe,
        input  out_data,
        input  char_ready,
        output char_valid,
        output char_data
    );

    modport slave (
        output out_strobe,
        output out_data,
        output char_ready,
        input  char_valid,
        input  char_data
    );
endinterface

// File: rtl/out_decimal_sink.sv
// rtl/out_decimal_sink.sv - nic8 output port sink printing each byte as "%03d\n"
//
// Each byte strobed by the CPU is queued in a DEPTH-entry FIFO, converted to
// BCD by a sequential double-dabble engine (one step per clock), and emitted
// as four ASCII characters: hundreds, tens, ones, EOL.
//
// Ports:
//   clk        system clock, all state changes on posedge
//   reset      synchronous active-high reset
//   port       out_decimal_sink_if.master (CPU capture + character stream)
//   fifo_full  FIFO holds DEPTH entries
//   overflow   sticky: a strobe arrived while full and was dropped
//   busy       FSM not idle or FIFO non-empty
module out_decimal_sink #(
    parameter int         DEPTH = 4,
    parameter logic [7:0] EOL   = 8'h0A
) (
    input  logic               clk,
    input  logic               reset,
    out_decimal_sink_if.master port,
    output logic               fifo_full,
    output logic               overflow,
    output logic               busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;

    logic [1:0]    state;
    logic [7:0]    bin;
    logic [11:0]   bcd;
    logic [2:0]    shiftCnt;
    logic [1:0]    charIdx;

    logic          isFull;
    logic          isEmpty;
    logic          doPush;
    logic          doPop;
    logic          xfer;
    logic          lineDone;
    logic [11:0]   bcdAdj;
    logic [11:0]   bcdNext;
    logic [7:0]    binNext;

    assign isFull   = (count == FULL_COUNT);
    assign isEmpty  = (count == '0);
    assign xfer     = port.char_valid && port.char_ready;
    assign lineDone = (state == EMIT) && xfer && (charIdx == 2'd3);
    // The next line's pop coincides with the EOL transfer so lines run back to back.
    assign doPop    = !isEmpty && ((state == IDLE) || lineDone);
    // A strobe into a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign doPush   = port.out_strobe && !isFull;

    assign fifo_full = isFull;
    assign busy      = (state != IDLE) || !isEmpty;

    // One double-dabble step: correct every nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcdAdj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        {bcdNext, binNext} = {bcdAdj, bin} << 1;
    end

    function automatic logic [7:0] digitChar(input logic [11:0] b, input logic [1:0] idx);
        case (idx)
            2'd0:    digitChar = 8'h30 + {4'd0, b[11:8]};
            2'd1:    digitChar = 8'h30 + {4'd0, b[7:4]};
            2'd2:    digitChar = 8'h30 + {4'd0, b[3:0]};
            default: digitChar = EOL;
        endcase
    endfunction

    // FIFO storage carries no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (!reset && doPush) begin
            mem[tail] <= port.out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                tail <= tail + 1'b1;
            end
            if (doPop) begin
                head <= head + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (port.out_strobe && isFull) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bin             <= '0;
            bcd             <= '0;
            shiftCnt        <= '0;
            charIdx         <= '0;
            port.char_valid <= 1'b0;
            port.char_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (doPop) begin
                        bin      <= mem[head];
                        bcd      <= '0;
                        shiftCnt <= '0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bin      <= binNext;
                    bcd      <= bcdNext;
                    shiftCnt <= shiftCnt + 1'b1;
                    if (shiftCnt == 3'd7) begin
                        // Present the hundreds digit straight from the final step.
                        state           <= EMIT;
                        charIdx         <= 2'd0;
                        port.char_valid <= 1'b1;
                        port.char_data  <= digitChar(bcdNext, 2'd0);
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (charIdx == 2'd3) begin
                            port.char_valid <= 1'b0;
                            charIdx         <= 2'd0;
                            if (doPop) begin
                                bin      <= mem[head];
                                bcd      <= '0;
                                shiftCnt <= '0;
                                state    <= CONV;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            charIdx        <= charIdx + 2'd1;
                            port.char_data <= digitChar(bcd, charIdx + 2'd1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_out_decimal_sink.sv
// tb/tb_out_decimal_sink.sv - self-checking bench for out_decimal_sink
module tb_out_decimal_sink;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fifo_full;
    logic overflow;
    logic busy;

    int total = 0;
    int bad = 0;

    logic [7:0] q[$];

    out_decimal_sink_if bus ();

    out_decimal_sink #(.DEPTH(4), .EOL(8'h0A)) dut (
        .clk       (clk),
        .reset     (reset),
        .port      (bus),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Record a character at the negedge before the posedge that transfers it.
    always @(negedge clk) begin
        if (!reset && bus.char_valid && bus.char_ready) begin
            q.push_back(bus.char_data);
        end
    end

    typedef struct {
        logic [7:0]  value;
        logic [31:0] expLine;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic strobeByte(input logic [7:0] v);
        bus.out_data   = v;
        bus.out_strobe = 1'b1;
        step();
        bus.out_strobe = 1'b0;
    endtask

    task automatic waitChars(input string name, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (q.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        if (q.size() < n) begin
            check({name, "_timeout"}, 32'(q.size()), 32'(n));
        end
        step();
    endtask

    task automatic popLine(output logic [31:0] w);
        w = 32'hxxxxxxxx;
        if (q.size() >= 4) begin
            w = {q[0], q[1], q[2], q[3]};
            repeat (4) void'(q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] line;
        int cyc;

        vecs[0] = '{8'd0,   {"000", 8'h0A}};
        vecs[1] = '{8'd9,   {"009", 8'h0A}};
        vecs[2] = '{8'd100, {"100", 8'h0A}};
        vecs[3] = '{8'd255, {"255", 8'h0A}};
        vecs[4] = '{8'd199, {"199", 8'h0A}};
        vecs[5] = '{8'd58,  {"058", 8'h0A}};
        vecs[6] = '{8'd128, {"128", 8'h0A}};
        vecs[7] = '{8'd10,  {"010", 8'h0A}};

        // Reset held two cycles with strobe active: nothing captured.
        bus.out_strobe = 1'b1;
        bus.out_data   = 8'd55;
        bus.char_ready = 1'b1;
        reset          = 1'b1;
        repeat (2) step();
        reset          = 1'b0;
        bus.out_strobe = 1'b0;
        check("rst_valid", 32'(bus.char_valid), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (20) step();
        check("rst_no_chars", 32'(q.size()), 32'd0);
        check("rst_busy_late", 32'(busy), 32'd0);

        // Single byte latency: valid rises after N+9.
        strobeByte(8'd42);
        repeat (8) step();
        check("lat_valid_n8", 32'(bus.char_valid), 32'd0);
        step();
        check("lat_valid_n9", 32'(bus.char_valid), 32'd1);
        check("lat_data_n9", 32'(bus.char_data), 32'h30);
        waitChars("lat", 4, 20);
        popLine(line);
        check("lat_line", line, {"042", 8'h0A});
        repeat (2) step();
        check("lat_busy", 32'(busy), 32'd0);

        // Table of values.
        for (int i = 0; i < 8; i++) begin
            q.delete();
            strobeByte(vecs[i].value);
            waitChars($sformatf("vec%0d", i), 4, 40);
            popLine(line);
            check($sformatf("vec%0d_line", i), line, vecs[i].expLine);
            repeat (5) step();
        end

        // Backpressure holds the first character stable.
        q.delete();
        bus.char_ready = 1'b0;
        strobeByte(8'd7);
        cyc = 0;
        while (!bus.char_valid && cyc < 30) begin
            step();
            cyc++;
        end
        check("bp_valid_seen", 32'(bus.char_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_hold%0d", i), {23'd0, bus.char_valid, bus.char_data}, {23'd0, 1'b1, 8'h30});
        end
        bus.char_ready = 1'b1;
        waitChars("bp", 4, 20);
        repeat (10) step();
        check("bp_count", 32'(q.size()), 32'd4);
        popLine(line);
        check("bp_line", line, {"007", 8'h0A});

        // Overflow: six strobes on consecutive edges with the stream stalled.
        q.delete();
        bus.char_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.out_data   = 8'(i);
            bus.out_strobe = 1'b1;
            step();
            if (i == 5) begin
                check("ovf_full_n4", 32'(fifo_full), 32'd1);
                check("ovf_clear_n4", 32'(overflow), 32'd0);
            end
        end
        bus.out_strobe = 1'b0;
        check("ovf_set_n5", 32'(overflow), 32'd1);
        bus.char_ready = 1'b1;
        waitChars("ovf", 20, 120);
        repeat (20) step();
        check("ovf_count", 32'(q.size()), 32'd20);
        for (int i = 1; i <= 5; i++) begin
            popLine(line);
            check($sformatf("ovf_line%0d", i), line, {"00", 8'(8'h30 + i), 8'h0A});
        end
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_idle", 32'(busy), 32'd0);

        // Reset after the second character of "123\n".
        q.delete();
        bus.char_ready = 1'b1;
        strobeByte(8'd123);
        repeat (11) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_valid", 32'(bus.char_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_overflow", 32'(overflow), 32'd0);
        check("mid_partial", {q.size() >= 2 ? {q[0], q[1]} : 16'hxxxx, 16'(q.size())}, {8'h31, 8'h32, 16'd2});
        step();
        check("mid_valid_later", 32'(bus.char_valid), 32'd0);
        q.delete();
        strobeByte(8'd8);
        waitChars("mid", 4, 40);
        repeat (15) step();
        check("mid_count", 32'(q.size()), 32'd4);
        popLine(line);
        check("mid_line", line, {"008", 8'h0A});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
